mem_lsu: RTL and testbench

Load/store unit that sits directly upstream of the word-only data memory (`mem`) in the Qrisc32 datapath. It accepts one byte, halfword or word load/store request at a time from the pipeline and checks alignment and the address limit. It drives the memory's registered-read / word-write port, extracts and extends sub-word load data, and performs sub-word stores as read-modify-write. Faulting requests never reach memory and are returned as an error response.

---
 rtl/mem_lsu.sv | 183 ++++++++++++++++++
 tb/tb_mem_lsu.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// Load/store unit in front of the word-only data memory. It handles one
// byte/half/word request at a time, rejects misaligned, out-of-range or
// illegal-size requests, and does sub-word stores as read-modify-write.
module mem_lsu #(
    parameter int ADR_LIMIT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_add_r,
    output logic        mem_rd,
    output logic [31:0] mem_add_w,
    output logic        mem_wr,
    output logic [31:0] mem_data_w,
    input  logic [31:0] mem_data_r
);

    localparam logic [31:0] LP_ADR_MAX = 32'(ADR_LIMIT * 4);
    localparam logic [1:0]  SZ_BYTE    = 2'd0;
    localparam logic [1:0]  SZ_HALF    = 2'd1;
    localparam logic [1:0]  SZ_WORD    = 2'd2;

    typedef enum logic [2:0] {S_IDLE, S_RD, S_RD_DATA, S_WR, S_RESP} state_t;

    state_t      r_state, w_state_nxt;
    logic        r_we, r_signed;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [15:0] r_wdata;

    logic        r_req_ready, r_resp_valid, r_resp_err, r_mem_rd, r_mem_wr;
    logic [31:0] r_resp_rdata, r_mem_add_r, r_mem_add_w, r_mem_data_w;

    logic        w_fault, w_err_nxt;
    logic [31:0] w_add_r_nxt, w_add_w_nxt, w_data_w_nxt, w_rdata_nxt;

    // A request faults on illegal size, misalignment or an address past the last word.
    function automatic logic f_fault(input logic [1:0] size, input logic [31:0] addr);
        return (size == 2'd3) ||
               ((size == SZ_HALF) && addr[0]) ||
               ((size == SZ_WORD) && (addr[1:0] != 2'b00)) ||
               (addr > LP_ADR_MAX);
    endfunction

    // Pick the addressed little-endian lane out of a memory word and extend it.
    function automatic logic [31:0] f_load_fmt(input logic [31:0] word, input logic [1:0] size,
                                               input logic sgn, input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(word >> {lane, 3'b000});
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: return {{24{sgn & b[7]}}, b};
            SZ_HALF: return {{16{sgn & h[15]}}, h};
            default: return word;
        endcase
    endfunction

    // Insert the low store bits into the addressed lane, keeping the other lanes.
    function automatic logic [31:0] f_store_merge(input logic [31:0] old, input logic [15:0] wd,
                                                  input logic [1:0] size, input logic [1:0] lane);
        logic [31:0] mask, ins;
        if (size == SZ_BYTE) begin
            mask = 32'h0000_00FF << {lane, 3'b000};
            ins  = {24'd0, wd[7:0]} << {lane, 3'b000};
        end else begin
            mask = 32'h0000_FFFF << {lane[1], 4'b0000};
            ins  = {16'd0, wd} << {lane[1], 4'b0000};
        end
        return (old & ~mask) | (ins & mask);
    endfunction

    assign w_fault = f_fault(req_size, req_addr);

    // Next-state and next-output decode; every output is registered from these values.
    always_comb begin
        w_state_nxt  = r_state;
        w_add_r_nxt  = r_mem_add_r;
        w_add_w_nxt  = r_mem_add_w;
        w_data_w_nxt = r_mem_data_w;
        w_rdata_nxt  = 32'd0;
        w_err_nxt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (w_fault) begin
                        w_state_nxt = S_RESP;
                        w_err_nxt   = 1'b1;
                    end else if (req_we && (req_size == SZ_WORD)) begin
                        w_state_nxt  = S_WR;
                        w_add_w_nxt  = {req_addr[31:2], 2'b00};
                        w_data_w_nxt = req_wdata;
                    end else begin
                        w_state_nxt = S_RD;
                        w_add_r_nxt = {req_addr[31:2], 2'b00};
                    end
                end
            end
            S_RD:      w_state_nxt = S_RD_DATA;
            S_RD_DATA: begin
                if (r_we) begin
                    w_state_nxt  = S_WR;
                    w_add_w_nxt  = {r_addr[31:2], 2'b00};
                    w_data_w_nxt = f_store_merge(mem_data_r, r_wdata, r_size, r_addr[1:0]);
                end else begin
                    w_state_nxt = S_RESP;
                    w_rdata_nxt = f_load_fmt(mem_data_r, r_size, r_signed, r_addr[1:0]);
                end
            end
            S_WR:      w_state_nxt = S_RESP;
            S_RESP:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Capture the request fields on accept; they are needed after the request is gone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we     <= 1'b0;
            r_signed <= 1'b0;
            r_size   <= 2'd0;
            r_addr   <= 32'd0;
            r_wdata  <= 16'd0;
        end else if ((r_state == S_IDLE) && req_valid) begin
            r_we     <= req_we;
            r_signed <= req_signed;
            r_size   <= req_size;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata[15:0];
        end
    end

    // Output registers, decoded from the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_mem_rd     <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_mem_add_r  <= 32'd0;
            r_mem_add_w  <= 32'd0;
            r_mem_data_w <= 32'd0;
        end else begin
            r_req_ready  <= (w_state_nxt == S_IDLE);
            r_resp_valid <= (w_state_nxt == S_RESP);
            r_resp_err   <= w_err_nxt;
            r_resp_rdata <= w_rdata_nxt;
            r_mem_rd     <= (w_state_nxt == S_RD);
            r_mem_wr     <= (w_state_nxt == S_WR);
            r_mem_add_r  <= w_add_r_nxt;
            r_mem_add_w  <= w_add_w_nxt;
            r_mem_data_w <= w_data_w_nxt;
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign resp_rdata = r_resp_rdata;
    assign mem_rd     = r_mem_rd;
    assign mem_wr     = r_mem_wr;
    assign mem_add_r  = r_mem_add_r;
    assign mem_add_w  = r_mem_add_w;
    assign mem_data_w = r_mem_data_w;

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: a word memory with registered read, plus a byte-array
// reference of the architectural memory contents used to predict results.
module tb_mem_lsu;

    localparam int LIM = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1, req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic        req_ready, resp_valid, resp_err, mem_rd, mem_wr;
    logic [31:0] resp_rdata, mem_add_r, mem_add_w, mem_data_w;
    logic [31:0] mem_data_r = 32'd0;

    logic [31:0] mem_arr [0:LIM];
    logic [7:0]  ref_b   [0:LIM*4+3];

    int n_vec = 0, n_err = 0;

    int          o_lat, o_nrd, o_nwr;
    logic        o_both, o_err;
    logic [31:0] o_rdata, o_wadr, o_wdat;

    int          e_lat, e_nrd, e_nwr;
    logic        e_err;
    logic [31:0] e_rdata;

    mem_lsu #(.ADR_LIMIT(LIM)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_add_r(mem_add_r), .mem_rd(mem_rd), .mem_add_w(mem_add_w),
        .mem_wr(mem_wr), .mem_data_w(mem_data_w), .mem_data_r(mem_data_r)
    );

    // Word memory: writes on wr, reads every cycle with one cycle of latency.
    always @(posedge clk) begin
        if (mem_wr && (mem_add_w <= 32'(LIM * 4))) mem_arr[mem_add_w[8:2]] <= mem_data_w;
        mem_data_r <= (mem_add_r <= 32'(LIM * 4)) ? mem_arr[mem_add_r[8:2]] : 32'd0;
    end

    // Reference: result, fault and access counts from the request rules, on a byte array.
    task automatic model(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] adr, input logic [31:0] wd);
        int nb;
        logic [8:0] ix;
        nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        e_err = (sz == 2'd3) || (nb == 2 && adr[0]) || (nb == 4 && adr[1:0] != 2'b00) ||
                (adr > 32'(LIM * 4));
        e_rdata = 32'd0; e_nrd = 0; e_nwr = 0;
        if (e_err) begin
            e_lat = 1;
        end else if (we) begin
            e_lat = (nb == 4) ? 2 : 4;
            e_nwr = 1;
            e_nrd = (nb == 4) ? 0 : 1;
            for (int i = 0; i < nb; i++) begin
                ix = 9'(adr + 32'(i));
                ref_b[ix] = 8'(wd >> (8 * i));
            end
        end else begin
            e_lat = 3;
            e_nrd = 1;
            for (int i = 0; i < nb; i++) begin
                ix = 9'(adr + 32'(i));
                e_rdata = e_rdata | (32'(ref_b[ix]) << (8 * i));
            end
            if (sg && nb < 4 && e_rdata[5'(8 * nb - 1)]) e_rdata = e_rdata | (32'hFFFF_FFFF << (8 * nb));
        end
    endtask

    // Issue one request and watch the DUT until its response (bounded).
    task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                          input logic [31:0] adr, input logic [31:0] wd);
        bit done;
        o_lat = 0; o_nrd = 0; o_nwr = 0; o_both = 1'b0; o_err = 1'bx;
        o_rdata = 32'hxxxx_xxxx; o_wadr = 32'hxxxx_xxxx; o_wdat = 32'hxxxx_xxxx;
        @(negedge clk);
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
        req_addr = adr; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        done = 1'b0;
        for (int c = 1; c <= 20 && !done; c++) begin
            @(negedge clk);
            if (mem_rd) o_nrd++;
            if (mem_wr) begin o_nwr++; o_wadr = mem_add_w; o_wdat = mem_data_w; end
            if (mem_rd && mem_wr) o_both = 1'b1;
            if (resp_valid) begin o_lat = c; o_err = resp_err; o_rdata = resp_rdata; done = 1'b1; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got %b want 1", req_ready); end
        n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL rst_resp_valid got %b want 0", resp_valid); end
        n_vec++; if (resp_err !== 1'b0) begin n_err++; $display("FAIL rst_resp_err got %b want 0", resp_err); end
        n_vec++; if (resp_rdata !== 32'd0) begin n_err++; $display("FAIL rst_rdata got %h want 0", resp_rdata); end
        n_vec++; if (mem_rd !== 1'b0) begin n_err++; $display("FAIL rst_mem_rd got %b want 0", mem_rd); end
        n_vec++; if (mem_wr !== 1'b0) begin n_err++; $display("FAIL rst_mem_wr got %b want 0", mem_wr); end
        n_vec++; if (mem_add_r !== 32'd0) begin n_err++; $display("FAIL rst_add_r got %h want 0", mem_add_r); end
        n_vec++; if (mem_data_w !== 32'd0) begin n_err++; $display("FAIL rst_data_w got %h want 0", mem_data_w); end
        reset = 1'b0;
        @(negedge clk);
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready_after got %b want 1", req_ready); end
    endtask

    task automatic test_word();
        model(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
        n_vec++; if (o_lat !== 2) begin n_err++; $display("FAIL wst_lat got %0d want 2", o_lat); end
        n_vec++; if (o_nwr !== 1 || o_nrd !== 0) begin n_err++; $display("FAIL wst_access got rd=%0d wr=%0d want rd=0 wr=1", o_nrd, o_nwr); end
        n_vec++; if (o_wadr !== 32'h10) begin n_err++; $display("FAIL wst_add_w got %h want 00000010", o_wadr); end
        n_vec++; if (o_wdat !== 32'hDEADBEEF) begin n_err++; $display("FAIL wst_data_w got %h want deadbeef", o_wdat); end
        n_vec++; if (o_err !== 1'b0 || o_rdata !== 32'd0) begin n_err++; $display("FAIL wst_resp got err=%b rdata=%h want err=0 rdata=0", o_err, o_rdata); end
        model(1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
        n_vec++; if (o_lat !== 3) begin n_err++; $display("FAIL wld_lat got %0d want 3", o_lat); end
        n_vec++; if (o_rdata !== 32'hDEADBEEF || o_err !== 1'b0) begin n_err++; $display("FAIL wld_data got %h err=%b want deadbeef err=0", o_rdata, o_err); end
        n_vec++; if (o_nrd !== 1 || o_nwr !== 0) begin n_err++; $display("FAIL wld_access got rd=%0d wr=%0d want rd=1 wr=0", o_nrd, o_nwr); end
    endtask

    task automatic test_subword_load();
        logic [31:0] ta [0:2];
        logic [1:0]  tz [0:2];
        logic        ts [0:2];
        logic [31:0] tx [0:2];
        ta[0] = 32'h13; tz[0] = 2'd0; ts[0] = 1'b1; tx[0] = 32'hFFFFFF80;
        ta[1] = 32'h12; tz[1] = 2'd0; ts[1] = 1'b0; tx[1] = 32'h000000FF;
        ta[2] = 32'h10; tz[2] = 2'd1; ts[2] = 1'b1; tx[2] = 32'h00007F01;
        model(1'b1, 2'd2, 1'b0, 32'h10, 32'h80FF7F01);
        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h80FF7F01);
        n_vec++; if (o_lat !== 2) begin n_err++; $display("FAIL swl_prep_lat got %0d want 2", o_lat); end
        for (int k = 0; k < 3; k++) begin
            model(1'b0, tz[k], ts[k], ta[k], 32'd0);
            do_req(1'b0, tz[k], ts[k], ta[k], 32'd0);
            n_vec++; if (o_rdata !== tx[k] || o_err !== 1'b0) begin n_err++; $display("FAIL swl_data[%0d] got %h err=%b want %h err=0", k, o_rdata, o_err, tx[k]); end
            n_vec++; if (o_lat !== 3) begin n_err++; $display("FAIL swl_lat[%0d] got %0d want 3", k, o_lat); end
        end
    endtask

    task automatic test_rmw();
        model(1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344);
        do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344);
        model(1'b1, 2'd0, 1'b0, 32'h21, 32'h000000AA);
        do_req(1'b1, 2'd0, 1'b0, 32'h21, 32'h000000AA);
        n_vec++; if (o_lat !== 4) begin n_err++; $display("FAIL rmw_lat got %0d want 4", o_lat); end
        n_vec++; if (o_nrd !== 1 || o_nwr !== 1 || o_both !== 1'b0) begin n_err++; $display("FAIL rmw_access got rd=%0d wr=%0d both=%b want 1 1 0", o_nrd, o_nwr, o_both); end
        n_vec++; if (o_wdat !== 32'h1122AA44 || o_wadr !== 32'h20) begin n_err++; $display("FAIL rmw_write got %h@%h want 1122aa44@00000020", o_wdat, o_wadr); end
        n_vec++; if (o_rdata !== 32'd0 || o_err !== 1'b0) begin n_err++; $display("FAIL rmw_resp got rdata=%h err=%b want 0 0", o_rdata, o_err); end
        model(1'b0, 2'd2, 1'b0, 32'h20, 32'd0);
        do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'd0);
        n_vec++; if (o_rdata !== 32'h1122AA44) begin n_err++; $display("FAIL rmw_readback got %h want 1122aa44", o_rdata); end
    endtask

    task automatic test_faults();
        logic        fw [0:3];
        logic [1:0]  fz [0:3];
        logic [31:0] fa [0:3];
        fw[0] = 1'b0; fz[0] = 2'd2; fa[0] = 32'h0A;
        fw[1] = 1'b1; fz[1] = 2'd1; fa[1] = 32'h05;
        fw[2] = 1'b0; fz[2] = 2'd2; fa[2] = 32'h104;
        fw[3] = 1'b0; fz[3] = 2'd3; fa[3] = 32'h10;
        for (int k = 0; k < 4; k++) begin
            do_req(fw[k], fz[k], 1'b0, fa[k], 32'hFFFF_FFFF);
            n_vec++; if (o_lat !== 1 || o_err !== 1'b1) begin n_err++; $display("FAIL fault_resp[%0d] got lat=%0d err=%b want lat=1 err=1", k, o_lat, o_err); end
            n_vec++; if (o_nrd !== 0 || o_nwr !== 0 || o_rdata !== 32'd0) begin n_err++; $display("FAIL fault_quiet[%0d] got rd=%0d wr=%0d rdata=%h want 0 0 0", k, o_nrd, o_nwr, o_rdata); end
        end
        model(1'b0, 2'd2, 1'b0, 32'h100, 32'd0);
        do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'd0);
        n_vec++; if (o_lat !== 3 || o_err !== 1'b0 || o_rdata !== e_rdata) begin n_err++; $display("FAIL limit_ok got lat=%0d err=%b rdata=%h want 3 0 %h", o_lat, o_err, o_rdata, e_rdata); end
    endtask

    task automatic test_reset_mid();
        bit seen_wr, seen_resp;
        @(negedge clk);
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd1; req_signed = 1'b0;
        req_addr = 32'h22; req_wdata = 32'h0000BEEF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        seen_wr = 1'b0;
        for (int c = 0; c < 10 && !seen_wr; c++) begin
            @(negedge clk);
            if (mem_wr) seen_wr = 1'b1;
        end
        n_vec++; if (!seen_wr) begin n_err++; $display("FAIL rstmid_reach_wr got none want mem_wr"); end
        reset = 1'b1;
        #1;
        n_vec++; if (mem_wr !== 1'b0) begin n_err++; $display("FAIL rstmid_wr_drop got %b want 0", mem_wr); end
        n_vec++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_ctrl got ready=%b resp=%b want 1 0", req_ready, resp_valid); end
        @(negedge clk);
        reset = 1'b0;
        seen_resp = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid) seen_resp = 1'b1;
        end
        n_vec++; if (seen_resp) begin n_err++; $display("FAIL rstmid_no_resp got resp_valid want none"); end
        n_vec++; if (mem_arr[8] !== 32'h1122AA44) begin n_err++; $display("FAIL rstmid_mem got %h want 1122aa44", mem_arr[8]); end
        model(1'b0, 2'd2, 1'b0, 32'h20, 32'd0);
        do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'd0);
        n_vec++; if (o_rdata !== 32'h1122AA44 || o_lat !== 3) begin n_err++; $display("FAIL rstmid_readback got %h lat=%0d want 1122aa44 lat=3", o_rdata, o_lat); end
    endtask

    // Present request k of the alternating store/load stream.
    task automatic drive_b2b(input int k, input logic [31:0] d);
        req_valid  = 1'b1;
        req_we     = (k % 2 == 0);
        req_size   = 2'd2;
        req_signed = 1'b0;
        req_addr   = 32'h40 + 32'(4 * (k / 2));
        req_wdata  = d;
        model(req_we, 2'd2, 1'b0, req_addr, d);
    endtask

    task automatic test_back_to_back();
        logic [31:0] dat [0:9];
        logic [31:0] exp;
        int acc, rsp, cyc;
        logic prev;
        bit took;
        for (int k = 0; k < 10; k++) dat[k] = $urandom;
        acc = 0; rsp = 0; cyc = 0; prev = 1'b0;
        @(negedge clk);
        drive_b2b(0, dat[0]);
        while (rsp < 10 && cyc < 300) begin
            took = 1'b0;
            if (resp_valid) begin
                n_vec++; if (prev) begin n_err++; $display("FAIL b2b_consecutive resp_valid high twice at rsp %0d", rsp); end
                exp = (rsp % 2 == 1) ? dat[rsp - 1] : 32'd0;
                n_vec++; if (resp_rdata !== exp || resp_err !== 1'b0) begin n_err++; $display("FAIL b2b_data[%0d] got %h err=%b want %h err=0", rsp, resp_rdata, resp_err, exp); end
                rsp++;
            end
            prev = resp_valid;
            if (req_valid && req_ready) begin
                n_vec++; if (acc !== rsp) begin n_err++; $display("FAIL b2b_outstanding got acc=%0d rsp=%0d want equal", acc, rsp); end
                acc++;
                took = 1'b1;
            end
            @(posedge clk);
            #1;
            if (acc >= 10) req_valid = 1'b0;
            else if (took) drive_b2b(acc, dat[acc]);
            @(negedge clk);
            cyc++;
        end
        req_valid = 1'b0;
        n_vec++; if (acc !== 10 || rsp !== 10) begin n_err++; $display("FAIL b2b_count got acc=%0d rsp=%0d want 10 10", acc, rsp); end
    endtask

    task automatic test_random();
        logic        we, sg;
        logic [1:0]  sz;
        logic [31:0] adr, wd;
        for (int n = 0; n < 60; n++) begin
            we  = 1'($urandom % 2);
            sg  = 1'($urandom % 2);
            sz  = ($urandom % 8 == 0) ? 2'd3 : 2'($urandom % 3);
            adr = $urandom_range(0, 32'h10C);
            if ($urandom % 4 != 0) adr = adr & ((sz == 2'd2) ? 32'hFFFF_FFFC : (sz == 2'd1) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF);
            wd  = $urandom;
            model(we, sz, sg, adr, wd);
            do_req(we, sz, sg, adr, wd);
            n_vec++; if (o_lat !== e_lat) begin n_err++; $display("FAIL rnd_lat[%0d] we=%b sz=%0d a=%h got %0d want %0d", n, we, sz, adr, o_lat, e_lat); end
            n_vec++; if (o_err !== e_err) begin n_err++; $display("FAIL rnd_err[%0d] a=%h got %b want %b", n, adr, o_err, e_err); end
            n_vec++; if (o_rdata !== e_rdata) begin n_err++; $display("FAIL rnd_rdata[%0d] we=%b sz=%0d sg=%b a=%h got %h want %h", n, we, sz, sg, adr, o_rdata, e_rdata); end
            n_vec++; if (o_nrd !== e_nrd || o_nwr !== e_nwr || o_both !== 1'b0) begin n_err++; $display("FAIL rnd_access[%0d] got rd=%0d wr=%0d both=%b want %0d %0d 0", n, o_nrd, o_nwr, o_both, e_nrd, e_nwr); end
        end
    endtask

    initial begin
        for (int i = 0; i <= LIM; i++) mem_arr[i] = 32'd0;
        for (int i = 0; i < LIM * 4 + 4; i++) ref_b[i] = 8'd0;
        test_reset();
        test_word();
        test_subword_load();
        test_rmw();
        test_faults();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
